// File: rtl/midi_pkg.sv
// Shared constants, FSM encoding and event bundle for the MIDI voice allocator.
// Byte classification helpers used by the parser.
package midi_pkg;

  localparam logic [7:0] ST_NOTE_OFF = 8'h80;
  localparam logic [7:0] ST_NOTE_ON  = 8'h90;
  localparam logic [7:0] RT_MIN      = 8'hF8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA1,
    S_DATA2,
    S_SCAN,
    S_EMIT
  } state_t;

  typedef struct packed {
    logic       status;
    logic [7:0] idx;
    logic [6:0] note;
    logic [6:0] vel;
  } voice_evt_t;

  function automatic logic is_rt(input logic [7:0] b);
    return b >= RT_MIN;
  endfunction

  function automatic logic is_note_st(input logic [7:0] b);
    return (b[7:4] == ST_NOTE_OFF[7:4]) ||
           (b[7:4] == ST_NOTE_ON[7:4]);
  endfunction

endpackage

// File: rtl/midi_voice_allocator_if.sv
// Byte input and voice-event output bundle of the allocator.
// slave: allocator side, master: byte source / event sink side.
interface midi_voice_allocator_if;
  logic [7:0] midi_byte_in;
  logic       midi_byte_valid;
  logic       SPI_note_status;
  logic [7:0] SPI_voice_index;
  logic [6:0] SPI_midi_note;
  logic [6:0] SPI_velocity;
  logic       SPI_ready_flag;
  logic [7:0] active_count;
  logic       byte_overflow;

  modport slave (
    input  midi_byte_in, midi_byte_valid,
    output SPI_note_status, SPI_voice_index,
    output SPI_midi_note, SPI_velocity,
    output SPI_ready_flag, active_count,
    output byte_overflow
  );

  modport master (
    output midi_byte_in, midi_byte_valid,
    input  SPI_note_status, SPI_voice_index,
    input  SPI_midi_note, SPI_velocity,
    input  SPI_ready_flag, active_count,
    input  byte_overflow
  );
endinterface

// File: rtl/voice_slot_table.sv
// Voice slot storage: valid bit and note per slot plus occupancy count.
// Ports: one combinational read port, one write port, count_o.
module voice_slot_table #(
  parameter int NUM_VOICES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rd_idx_i,
  output logic       rd_valid_o,
  output logic [6:0] rd_note_o,
  input  logic       wr_en_i,
  input  logic [7:0] wr_idx_i,
  input  logic       wr_valid_i,
  input  logic [6:0] wr_note_i,
  output logic [7:0] count_o
);

  logic [NUM_VOICES-1:0] valid_q;
  logic [6:0]            note_q [NUM_VOICES];
  logic [7:0]            count_q;
  logic                  wr_old;

  always_comb begin
    rd_valid_o = 1'b0;
    rd_note_o  = 7'd0;
    wr_old     = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (rd_idx_i == 8'(i)) begin
        rd_valid_o = valid_q[i];
        rd_note_o  = note_q[i];
      end
      if (wr_idx_i == 8'(i))
        wr_old = valid_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      count_q <= 8'd0;
      for (int i = 0; i < NUM_VOICES; i++)
        note_q[i] <= 7'd0;
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (wr_en_i && wr_idx_i == 8'(i)) begin
          valid_q[i] <= wr_valid_i;
          note_q[i]  <= wr_note_i;
        end
      end
      // Steal/retrigger rewrite an occupied slot: count unchanged.
      if (wr_en_i && wr_valid_i && !wr_old)
        count_q <= count_q + 8'd1;
      else if (wr_en_i && !wr_valid_i && wr_old)
        count_q <= count_q - 8'd1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/midi_voice_allocator.sv
// MIDI note-on/off parser with linear-scan voice slot allocation.
// Ports: clk, reset (async active-low), bus (byte in, voice event out).
module midi_voice_allocator
  import midi_pkg::*;
#(
  parameter int NUM_VOICES = 16
) (
  input  logic clk,
  input  logic reset,
  midi_voice_allocator_if.slave bus
);

  localparam logic [7:0] LAST = 8'(NUM_VOICES - 1);

  state_t     state_q;
  logic       rs_valid_q, rs_on_q;
  logic [6:0] note_q, vel_q;
  logic       msg_on_q;
  logic [7:0] scan_idx_q;
  logic       match_q, free_q;
  logic [7:0] match_idx_q, free_idx_q;
  logic [7:0] sel_idx_q, steal_ptr_q;
  logic       steal_q;
  logic       pend_valid_q;
  logic [7:0] pend_byte_q;
  voice_evt_t evt_q;
  logic       ready_q, ovf_q;

  logic       rd_valid;
  logic [6:0] rd_note;
  logic       hit, last, match_f, free_f;
  logic [7:0] match_idx_f, free_idx_f;
  logic [7:0] b;
  logic       have_b, in_rt;

  voice_slot_table #(.NUM_VOICES(NUM_VOICES)) u_tbl (
    .clk       (clk),
    .rst_n     (reset),
    .rd_idx_i  (scan_idx_q),
    .rd_valid_o(rd_valid),
    .rd_note_o (rd_note),
    .wr_en_i   (state_q == S_EMIT),
    .wr_idx_i  (sel_idx_q),
    .wr_valid_i(msg_on_q),
    .wr_note_i (note_q),
    .count_o   (bus.active_count)
  );

  // Pending byte is always older than the live input.
  assign b      = pend_valid_q ? pend_byte_q : bus.midi_byte_in;
  assign have_b = pend_valid_q | bus.midi_byte_valid;
  assign in_rt  = is_rt(bus.midi_byte_in);

  assign hit  = rd_valid && (rd_note == note_q);
  assign last = (scan_idx_q == LAST);

  // Results including the slot examined this cycle.
  assign match_f     = match_q | hit;
  assign match_idx_f = match_q ? match_idx_q : scan_idx_q;
  assign free_f      = free_q | ~rd_valid;
  assign free_idx_f  = free_q ? free_idx_q : scan_idx_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      rs_valid_q   <= 1'b0;
      rs_on_q      <= 1'b0;
      note_q       <= 7'd0;
      vel_q        <= 7'd0;
      msg_on_q     <= 1'b0;
      scan_idx_q   <= 8'd0;
      match_q      <= 1'b0;
      free_q       <= 1'b0;
      match_idx_q  <= 8'd0;
      free_idx_q   <= 8'd0;
      sel_idx_q    <= 8'd0;
      steal_ptr_q  <= 8'd0;
      steal_q      <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_byte_q  <= 8'd0;
      evt_q        <= '0;
      ready_q      <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      ovf_q   <= 1'b0;
      case (state_q)
        S_IDLE, S_DATA1, S_DATA2: begin
          if (pend_valid_q) begin
            if (bus.midi_byte_valid && !in_rt)
              pend_byte_q <= bus.midi_byte_in;
            else
              pend_valid_q <= 1'b0;
          end
          if (have_b && !is_rt(b)) begin
            if (b[7]) begin
              if (is_note_st(b)) begin
                rs_valid_q <= 1'b1;
                rs_on_q    <= (b[7:4] == ST_NOTE_ON[7:4]);
                state_q    <= S_DATA1;
              end else begin
                rs_valid_q <= 1'b0;
                state_q    <= S_IDLE;
              end
            end else if (state_q == S_DATA2) begin
              vel_q       <= b[6:0];
              msg_on_q    <= rs_on_q && (b[6:0] != 7'd0);
              scan_idx_q  <= 8'd0;
              match_q     <= 1'b0;
              free_q      <= 1'b0;
              state_q     <= S_SCAN;
            end else if (state_q == S_DATA1 || rs_valid_q) begin
              note_q  <= b[6:0];
              state_q <= S_DATA2;
            end
          end
        end

        S_SCAN: begin
          if (bus.midi_byte_valid && !in_rt) begin
            if (!pend_valid_q) begin
              pend_valid_q <= 1'b1;
              pend_byte_q  <= bus.midi_byte_in;
            end else begin
              ovf_q <= 1'b1;
            end
          end
          if (hit && !match_q) begin
            match_q     <= 1'b1;
            match_idx_q <= scan_idx_q;
          end
          if (!rd_valid && !free_q) begin
            free_q     <= 1'b1;
            free_idx_q <= scan_idx_q;
          end
          scan_idx_q <= scan_idx_q + 8'd1;
          if (last) begin
            steal_q <= 1'b0;
            if (msg_on_q) begin
              state_q <= S_EMIT;
              if (match_f)
                sel_idx_q <= match_idx_f;
              else if (free_f)
                sel_idx_q <= free_idx_f;
              else begin
                sel_idx_q <= steal_ptr_q;
                steal_q   <= 1'b1;
              end
            end else if (match_f) begin
              sel_idx_q <= match_idx_f;
              state_q   <= S_EMIT;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end

        S_EMIT: begin
          if (bus.midi_byte_valid && !in_rt) begin
            if (!pend_valid_q) begin
              pend_valid_q <= 1'b1;
              pend_byte_q  <= bus.midi_byte_in;
            end else begin
              ovf_q <= 1'b1;
            end
          end
          evt_q.status <= msg_on_q;
          evt_q.idx    <= sel_idx_q;
          evt_q.note   <= note_q;
          evt_q.vel    <= msg_on_q ? vel_q : 7'd0;
          ready_q      <= 1'b1;
          if (steal_q)
            steal_ptr_q <= (steal_ptr_q == LAST) ?
                           8'd0 : steal_ptr_q + 8'd1;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.SPI_note_status = evt_q.status;
  assign bus.SPI_voice_index = evt_q.idx;
  assign bus.SPI_midi_note   = evt_q.note;
  assign bus.SPI_velocity    = evt_q.vel;
  assign bus.SPI_ready_flag  = ready_q;
  assign bus.byte_overflow   = ovf_q;

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Self-checking bench for midi_voice_allocator.
// Directed scenarios plus randomized messages against a slot model.
module tb_midi_voice_allocator;

  localparam int NV = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  midi_voice_allocator_if bif();

  midi_voice_allocator #(.NUM_VOICES(NV)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bif)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ovf_cnt = 0;

  typedef struct {
    int          c;
    logic [30:0] v;
  } ev_t;
  ev_t evq[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bif.SPI_ready_flag === 1'b1)
      evq.push_back('{c: cyc, v: {bif.SPI_note_status,
        bif.SPI_voice_index, bif.SPI_midi_note,
        bif.SPI_velocity, bif.active_count}});
    if (bif.byte_overflow === 1'b1) ovf_cnt++;
  end

  // Reference model: slot contents as plain arrays.
  bit m_valid[NV];
  int m_note[NV];
  int m_steal, m_count;
  bit rs_ok, rs_on;

  function automatic void model_reset();
    for (int i = 0; i < NV; i++) begin
      m_valid[i] = 0;
      m_note[i] = 0;
    end
    m_steal = 0;
    m_count = 0;
  endfunction

  function automatic void model_msg(
    input bit on, input int note, input int vel,
    output bit emit, output logic [30:0] exp);
    int idx = -1;
    for (int i = 0; i < NV; i++)
      if (idx < 0 && m_valid[i] && m_note[i] == note) idx = i;
    emit = 1;
    if (on && vel > 0) begin
      if (idx < 0)
        for (int i = 0; i < NV; i++)
          if (idx < 0 && !m_valid[i]) begin
            idx = i;
            m_count++;
          end
      if (idx < 0) begin
        idx = m_steal;
        m_steal = (m_steal + 1) % NV;
      end
      m_valid[idx] = 1;
      m_note[idx] = note;
      exp = {1'b1, 8'(idx), 7'(note), 7'(vel), 8'(m_count)};
    end else if (idx >= 0) begin
      m_valid[idx] = 0;
      m_count--;
      exp = {1'b0, 8'(idx), 7'(note), 7'd0, 8'(m_count)};
    end else begin
      emit = 0;
      exp = '0;
    end
  endfunction

  task automatic send(input logic [7:0] b, output int c);
    bif.midi_byte_in = b;
    bif.midi_byte_valid = 1'b1;
    @(posedge clk);
    #1;
    bif.midi_byte_valid = 1'b0;
    c = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bif.midi_byte_valid = 1'b0;
    reset = 1'b0;
    idle(3);
    reset = 1'b1;
    idle(2);
    model_reset();
    evq.delete();
    ovf_cnt = 0;
    rs_ok = 0;
  endtask

  task automatic test_reset();
    logic [31:0] got;
    bif.midi_byte_in = 8'h00;
    bif.midi_byte_valid = 1'b0;
    idle(3);
    got = {bif.SPI_note_status, bif.SPI_voice_index,
           bif.SPI_midi_note, bif.SPI_velocity,
           bif.SPI_ready_flag};
    checks++;
    if (got !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h want=0", got);
    end
    checks++;
    if ({bif.active_count, bif.byte_overflow} !== 9'd0) begin
      errors++;
      $display("FAIL reset_count got=%h want=0",
               {bif.active_count, bif.byte_overflow});
    end
    reset = 1'b1;
    idle(2);
    model_reset();
  endtask

  // Sends one message, waits for the scan, checks vs model.
  task automatic run_msg(input string nm, input bit on,
      input int ch, input int note, input int vel,
      input bit use_rs, input bit rt);
    int c;
    bit emit;
    logic [30:0] exp;
    if (!use_rs)
      send({on ? 4'h9 : 4'h8, 4'(ch)}, c);
    rs_ok = 1;
    rs_on = on;
    send(8'(note), c);
    if (rt) send(8'hF8, c);
    send(8'(vel), c);
    idle(20);
    model_msg(on, note, vel, emit, exp);
    checks++;
    if (evq.size() !== (emit ? 1 : 0)) begin
      errors++;
      $display("FAIL %s_events got=%0d want=%0d",
               nm, evq.size(), emit);
    end else if (emit) begin
      checks++;
      if (evq[0].v !== exp || evq[0].c - c !== NV + 1) begin
        errors++;
        $display("FAIL %s_event got=%h lat=%0d want=%h lat=%0d",
                 nm, evq[0].v, evq[0].c - c, exp, NV + 1);
      end
    end
    checks++;
    if (bif.active_count !== 8'(m_count)) begin
      errors++;
      $display("FAIL %s_count got=%0d want=%0d",
               nm, bif.active_count, m_count);
    end
    evq.delete();
  endtask

  task automatic test_basic();
    do_reset();
    run_msg("note_on", 1, 0, 8'h3C, 8'h64, 0, 0);
    run_msg("run_status", 1, 0, 8'h40, 8'h50, 1, 0);
    run_msg("vel0_off", 1, 0, 8'h3C, 8'h00, 1, 0);
    run_msg("off_miss", 0, 0, 8'h7F, 8'h40, 0, 0);
    run_msg("off_hit", 0, 5, 8'h40, 8'h10, 0, 0);
  endtask

  task automatic test_steal();
    do_reset();
    for (int n = 8'h30; n <= 8'h41; n++)
      run_msg($sformatf("steal_%0h", n), 1, n % 16, n, 8'h20, 0, 0);
    checks++;
    if (m_steal !== 2 || bif.active_count !== 8'd16) begin
      errors++;
      $display("FAIL steal_final count=%0d want=16",
               bif.active_count);
    end
    run_msg("retrigger", 1, 0, 8'h35, 8'h7F, 0, 0);
  endtask

  task automatic test_realtime();
    int c;
    do_reset();
    run_msg("rt_between", 1, 0, 8'h3C, 8'h64, 0, 1);
    send(8'h90, c);
    send(8'h3D, c);
    send(8'hB0, c);
    send(8'h40, c);
    send(8'h3E, c);
    send(8'h40, c);
    idle(22);
    checks++;
    if (evq.size() !== 0 || bif.active_count !== 8'd1) begin
      errors++;
      $display("FAIL abort_msg events=%0d count=%0d want 0/1",
               evq.size(), bif.active_count);
    end
    evq.delete();
  endtask

  task automatic test_reset_scan();
    int c;
    logic [31:0] got;
    do_reset();
    run_msg("pre_reset", 1, 2, 8'h45, 8'h33, 0, 0);
    send(8'h90, c);
    send(8'h3D, c);
    send(8'h50, c);
    idle(5);
    reset = 1'b0;
    #1;
    got = {bif.SPI_note_status, bif.SPI_voice_index,
           bif.SPI_midi_note, bif.SPI_velocity,
           bif.SPI_ready_flag};
    checks++;
    if (got !== 32'd0 || bif.active_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid_scan got=%h cnt=%0d want=0",
               got, bif.active_count);
    end
    idle(2);
    reset = 1'b1;
    idle(30);
    checks++;
    if (evq.size() !== 0) begin
      errors++;
      $display("FAIL reset_no_pulse got=%0d want=0", evq.size());
    end
    model_reset();
    evq.delete();
  endtask

  task automatic test_overflow();
    int c, c2;
    bit emit;
    logic [30:0] exp;
    do_reset();
    send(8'h90, c);
    send(8'h3C, c);
    send(8'h64, c);
    send(8'h91, c2);
    send(8'h3D, c2);
    send(8'hF8, c2);
    idle(22);
    checks++;
    if (ovf_cnt !== 1) begin
      errors++;
      $display("FAIL overflow_pulses got=%0d want=1", ovf_cnt);
    end
    model_msg(1, 8'h3C, 8'h64, emit, exp);
    checks++;
    if (evq.size() !== 1 || evq[0].v !== exp ||
        evq[0].c - c !== NV + 1) begin
      errors++;
      $display("FAIL overflow_event n=%0d want=%h", evq.size(), exp);
    end
    evq.delete();
    // Pending status byte 0x91 must now be in effect.
    rs_ok = 1;
    rs_on = 1;
    run_msg("pending", 1, 1, 8'h3D, 8'h50, 1, 0);
  endtask

  task automatic test_random();
    bit on, use_rs;
    int note, vel;
    do_reset();
    for (int k = 0; k < 80; k++) begin
      on = ($urandom_range(0, 2) != 0);
      note = $urandom_range(32, 55);
      vel = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 127);
      use_rs = rs_ok && rs_on == on && $urandom_range(0, 1) == 1;
      run_msg("random", on, $urandom_range(0, 15), note, vel,
              use_rs, $urandom_range(0, 3) == 0);
    end
  endtask

  initial begin
    bif.midi_byte_in = 8'h00;
    bif.midi_byte_valid = 1'b0;
    test_reset();
    test_basic();
    test_steal();
    test_realtime();
    test_reset_scan();
    test_overflow();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
